// File: rtl/serial_subtractor_if.sv
// Handshake and data bundle for serial_subtractor: start/a/b from the controller,
// registered result, flags and busy/done status back from the subtractor.
interface serial_subtractor_if #(
  parameter int WIDTH = 5
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             zero;
  logic             ovf;
  logic             busy;
  logic             done;

  modport master (
    output start, a, b,
    input  diff, borrow, zero, ovf, busy, done
  );

  modport slave (
    input  start, a, b,
    output diff, borrow, zero, ovf, busy, done
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial A - B, LSB first, one borrow flip-flop, start/busy/done handshake.
// Define SERIAL_SUB_OVF_EN to build the two's-complement overflow flag; otherwise ovf is tied to 0.
module serial_subtractor #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 6
) (
  input  logic                clk,
  input  logic                reset,
  serial_subtractor_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             bf;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             zero_q;
  logic             busy_q;
  logic             done_q;

  logic             d;
  logic             bf_next;
  logic [WIDTH-1:0] res_next;
  logic             last_bit;

  // NOTE: every signal here is assigned on every pass, so no latch can be inferred.
  always_comb begin
    d        = a_sh[0] ^ b_sh[0] ^ bf;
    bf_next  = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & bf);
    res_next = {d, res_sh[WIDTH-1:1]};
    last_bit = (cnt == CNT_W'(WIDTH - 1));
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      bf       <= 1'b0;
      cnt      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_sh   <= bus.a;
            b_sh   <= bus.b;
            res_sh <= '0;
            bf     <= 1'b0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= SHIFT;
          end
        end

        SHIFT: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_next;
          bf     <= bf_next;
          cnt    <= cnt + 1'b1;
          // Result flags update only here, so they never expose a partial difference.
          if (last_bit) begin
            diff_q   <= res_next;
            borrow_q <= bf_next;
            zero_q   <= ~|res_next;
            done_q   <= 1'b1;
            state    <= DONE;
          end
        end

        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  // Operand sign bits are shifted out during SHIFT, so they are kept aside at accept time.
  logic a_msb;
  logic b_msb;
  logic ovf_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      if (state == IDLE && bus.start) begin
        a_msb <= bus.a[WIDTH-1];
        b_msb <= bus.b[WIDTH-1];
      end
      if (state == SHIFT && last_bit) begin
        ovf_q <= (a_msb != b_msb) && (d != a_msb);
      end
    end
  end

  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif

  assign bus.diff   = diff_q;
  assign bus.borrow = borrow_q;
  assign bus.zero   = zero_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases plus random operands
// checked against an arithmetic reference model (modular difference, unsigned/signed compare).
module tb_serial_subtractor;

  localparam int WIDTH = 5;
  localparam int CNT_W = 6;
  localparam int MASK  = (1 << WIDTH) - 1;
  localparam int SMAX  = (1 << (WIDTH - 1)) - 1;
  localparam int SMIN  = -(1 << (WIDTH - 1));

  logic clk = 1'b0;
  logic reset;

  serial_subtractor_if #(.WIDTH(WIDTH)) sif ();

  serial_subtractor #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sif)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic int to_signed(input int v);
    return (v > SMAX) ? v - (1 << WIDTH) : v;
  endfunction

  // Reference: plain integer arithmetic on the operand values.
  function automatic void model(input int ia, input int ib,
                                output int ed, output bit eb, output bit ez, output bit eo);
    int sd;
    ed = (ia - ib) & MASK;
    eb = (ia < ib);
    ez = (ed == 0);
    sd = to_signed(ia) - to_signed(ib);
`ifdef SERIAL_SUB_OVF_EN
    eo = (sd > SMAX) || (sd < SMIN);
`else
    eo = 1'b0;
`endif
  endfunction

  task automatic run_op(input int ia, input int ib, input string tag);
    int               ed;
    bit               eb, ez, eo;
    int               lat;
    logic [WIDTH-1:0] prev_diff;
    model(ia, ib, ed, eb, ez, eo);
    prev_diff = sif.diff;
    @(negedge clk);
    sif.start = 1'b1;
    sif.a     = WIDTH'(ia);
    sif.b     = WIDTH'(ib);
    @(negedge clk);
    sif.start = 1'b0;
    sif.a     = WIDTH'($urandom);
    sif.b     = WIDTH'($urandom);
    check({tag, "_busy_rise"}, 32'(sif.busy), 32'd1);
    check({tag, "_diff_held"}, 32'(sif.diff), 32'(prev_diff));
    lat = 0;
    while (sif.done !== 1'b1 && lat < 4 * WIDTH) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(WIDTH));
    check({tag, "_diff"},    32'(sif.diff),   32'(ed));
    check({tag, "_borrow"},  32'(sif.borrow), 32'(eb));
    check({tag, "_zero"},    32'(sif.zero),   32'(ez));
    check({tag, "_ovf"},     32'(sif.ovf),    32'(eo));
    check({tag, "_busy_done"}, 32'(sif.busy), 32'd1);
    @(negedge clk);
    check({tag, "_done_fall"}, 32'(sif.done), 32'd0);
    check({tag, "_busy_fall"}, 32'(sif.busy), 32'd0);
  endtask

  initial begin
    int pulses;
    int first_done;
    int second_done;
    sif.start = 1'b0;
    sif.a     = '0;
    sif.b     = '0;
    reset     = 1'b1;
    #2;
    check("reset_diff",   32'(sif.diff),   32'd0);
    check("reset_borrow", 32'(sif.borrow), 32'd0);
    check("reset_zero",   32'(sif.zero),   32'd0);
    check("reset_ovf",    32'(sif.ovf),    32'd0);
    check("reset_busy",   32'(sif.busy),   32'd0);
    check("reset_done",   32'(sif.done),   32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    run_op(5'b11111, 5'b01010, "pos_result");
    run_op(5'b01010, 5'b11111, "neg_result");
    run_op(5'b10011, 5'b10011, "equal");
    run_op(5'b01111, 5'b10000, "signed_ovf");
    run_op(0, MASK, "zero_minus_max");
    run_op(MASK, 0, "max_minus_zero");

    // Second start two cycles into the first operation must be ignored.
    @(negedge clk);
    sif.start = 1'b1;
    sif.a     = 5'b11111;
    sif.b     = 5'b00001;
    @(negedge clk);
    sif.start = 1'b0;
    @(negedge clk);
    sif.start = 1'b1;
    sif.a     = 5'b00000;
    sif.b     = 5'b00001;
    @(negedge clk);
    sif.start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 3 * WIDTH; i++) begin
      if (sif.done === 1'b1) pulses++;
      @(negedge clk);
    end
    check("ignore_pulses", 32'(pulses),     32'd1);
    check("ignore_diff",   32'(sif.diff),   32'b11110);
    check("ignore_borrow", 32'(sif.borrow), 32'd0);
    check("ignore_idle",   32'(sif.busy),   32'd0);

    // Start held high: each return to IDLE accepts a new operation.
    sif.start   = 1'b1;
    sif.a       = 5'b00110;
    sif.b       = 5'b01001;
    first_done  = -1;
    second_done = -1;
    for (int i = 0; i < 3 * (WIDTH + 2); i++) begin
      @(negedge clk);
      if (sif.done === 1'b1) begin
        if (first_done < 0) first_done = i;
        else if (second_done < 0) second_done = i;
      end
    end
    sif.start = 1'b0;
    check("held_spacing", 32'(second_done - first_done), 32'(WIDTH + 2));
    check("held_diff",    32'(sif.diff),   32'b11101);
    check("held_borrow",  32'(sif.borrow), 32'd1);
    repeat (2 * WIDTH) @(negedge clk);
    check("held_idle",    32'(sif.busy),   32'd0);

    // Reset during SHIFT discards the operation with no done pulse.
    run_op(5'b11111, 5'b00001, "pre_reset");
    @(negedge clk);
    sif.start = 1'b1;
    sif.a     = 5'b10001;
    sif.b     = 5'b00100;
    @(negedge clk);
    sif.start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy", 32'(sif.busy), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_reset_diff",   32'(sif.diff),   32'd0);
    check("mid_reset_borrow", 32'(sif.borrow), 32'd0);
    check("mid_reset_zero",   32'(sif.zero),   32'd0);
    check("mid_reset_ovf",    32'(sif.ovf),    32'd0);
    check("mid_reset_busy",   32'(sif.busy),   32'd0);
    check("mid_reset_done",   32'(sif.done),   32'd0);
    @(negedge clk);
    @(negedge clk);
    reset  = 1'b0;
    pulses = 0;
    for (int i = 0; i < 2 * WIDTH; i++) begin
      @(negedge clk);
      if (sif.done === 1'b1) pulses++;
    end
    check("post_reset_no_done", 32'(pulses), 32'd0);
    run_op(5'b00101, 5'b00011, "after_reset");

    for (int i = 0; i < 20; i++) begin
      run_op(int'($urandom_range(0, MASK)), int'($urandom_range(0, MASK)), $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
